data_mem_responder: RTL

- Memory-side responder for the single-cycle MIPS core's data port. It answers the core's address, write-data and write-strobe with read data in the same cycle.
- Backs a word RAM plus a small MMIO window: an LED register, a free-running cycle counter, and a byte TX FIFO.
- The TX FIFO drains over a valid/ready stream toward a debug/UART transmitter.
- Sits beside the core at the top level of the FPGA build.

---
 rtl/data_mem_responder_pkg.sv | 37 +++
 rtl/data_mem_responder_fifo.sv | 65 ++++++
 rtl/data_mem_responder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-port responder: MMIO page, register
// offsets, TX_STATUS bit layout and the offset decoder.
package data_mem_responder_pkg;

   localparam logic [15:0] MMIO_PAGE     = 16'hFFFF;

   localparam logic [15:0] OFF_LED       = 16'h0000;
   localparam logic [15:0] OFF_CYCLE     = 16'h0004;
   localparam logic [15:0] OFF_TX_DATA   = 16'h0008;
   localparam logic [15:0] OFF_TX_STATUS = 16'h000C;

   // TX_STATUS layout: {24'b0, count[3:0], 1'b0, overflow, full, empty}
   localparam int ST_EMPTY_BIT  = 0;
   localparam int ST_FULL_BIT   = 1;
   localparam int ST_OVF_BIT    = 2;
   localparam int ST_COUNT_LSB  = 4;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_LED,
      REG_CYCLE,
      REG_TX_DATA,
      REG_TX_STATUS
   } mmio_reg_e;

   // Word-granular decode of the MMIO offset (byte lane bits already dropped).
   function automatic mmio_reg_e decode_offset(input logic [13:0] word_off);
      mmio_reg_e sel;
      sel = REG_NONE;
      if (word_off == OFF_LED[15:2])            sel = REG_LED;
      else if (word_off == OFF_CYCLE[15:2])     sel = REG_CYCLE;
      else if (word_off == OFF_TX_DATA[15:2])   sel = REG_TX_DATA;
      else if (word_off == OFF_TX_STATUS[15:2]) sel = REG_TX_STATUS;
      return sel;
   endfunction

endpackage

// File: rtl/data_mem_responder_fifo.sv
// Small synchronous FIFO with registered storage. A push while full is
// accepted only if a pop happens in the same cycle; otherwise it is dropped
// and drop_o pulses so the parent can keep a sticky overflow flag.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [CNT_W-1:0] count_o,
   output logic             drop_o
);

   logic [WIDTH-1:0] mem_q [0:DEPTH-1];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // Accept/drop decisions and next pointer/count values.
   always_comb begin
      do_pop   = pop_i && !empty_o;
      do_push  = push_i && (!full_o || do_pop);
      drop_o   = push_i && full_o && !do_pop;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
   end

   // Pointer and occupancy registers; reset empties the queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; a full push+pop overwrites the slot being popped.
   always_ff @(posedge clk) begin
      if (do_push && !rst) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder for the single-cycle MIPS core: asynchronous-read word
// RAM plus an MMIO page holding LEDs, a cycle counter and a byte TX FIFO.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic        mem_write,
   output logic [31:0] read_data,
   output logic [7:0]  leds,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]           ram_q [0:(1<<ADDR_WIDTH)-1];
   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  is_mmio;
   mmio_reg_e             sel;
   logic                  wr_led, wr_cycle, wr_tx, wr_status;

   logic [7:0]  leds_q, leds_d;
   logic [31:0] cycle_q, cycle_d;
   logic        ovf_q, ovf_d;

   logic             fifo_empty, fifo_full, fifo_drop;
   logic [CNT_W-1:0] fifo_count;
   logic [31:0]      status_word;

   // Byte-lane bits never influence a word access.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[1:0];

   assign is_mmio  = (addr[31:16] == MMIO_PAGE);
   assign sel      = is_mmio ? decode_offset(addr[15:2]) : REG_NONE;
   assign word_idx = addr[ADDR_WIDTH+1:2];

   assign wr_led    = mem_write && (sel == REG_LED);
   assign wr_cycle  = mem_write && (sel == REG_CYCLE);
   assign wr_tx     = mem_write && (sel == REG_TX_DATA);
   assign wr_status = mem_write && (sel == REG_TX_STATUS);

   // Word RAM store; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_write && !is_mmio) ram_q[word_idx] <= write_data;
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (wr_tx),
      .data_i  (write_data[7:0]),
      .pop_i   (tx_ready),
      .data_o  (tx_data),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .count_o (fifo_count),
      .drop_o  (fifo_drop)
   );

   assign tx_valid = !fifo_empty;
   assign leds     = leds_q;

   // Next-state for LEDs, cycle counter and sticky overflow (set beats clear).
   always_comb begin
      leds_d  = wr_led ? write_data[7:0] : leds_q;
      cycle_d = wr_cycle ? 32'd0 : cycle_q + 32'd1;
      ovf_d   = ovf_q;
      if (wr_status && write_data[ST_OVF_BIT]) ovf_d = 1'b0;
      if (fifo_drop)                           ovf_d = 1'b1;
   end

   // MMIO register state; stores in the reset cycle are discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         leds_q  <= 8'd0;
         cycle_q <= 32'd0;
         ovf_q   <= 1'b0;
      end else begin
         leds_q  <= leds_d;
         cycle_q <= cycle_d;
         ovf_q   <= ovf_d;
      end
   end

   // TX_STATUS image assembled from FIFO flags and the overflow flag.
   always_comb begin
      status_word                   = 32'd0;
      status_word[ST_EMPTY_BIT]     = fifo_empty;
      status_word[ST_FULL_BIT]      = fifo_full;
      status_word[ST_OVF_BIT]       = ovf_q;
      status_word[ST_COUNT_LSB +: 4] = 4'(fifo_count);
   end

   // Combinational load path: RAM word or selected MMIO register.
   always_comb begin
      read_data = 32'd0;
      if (!is_mmio) begin
         read_data = ram_q[word_idx];
      end else begin
         case (sel)
            REG_LED:       read_data = {24'd0, leds_q};
            REG_CYCLE:     read_data = cycle_q;
            REG_TX_STATUS: read_data = status_word;
            default:       read_data = 32'd0;
         endcase
      end
   end

endmodule
